cdc_handshake_src: RTL

- Source (launch) side of a multi-bit clock-domain-crossing handshake.
- Accepts a word on a valid/ready interface in its own clock domain and holds it on a stable bus for the destination domain.
- Signals each new word by toggling a request line.
- Synchronizes the returning toggle acknowledge from the destination through an internal NUM_STAGES flop chain. It accepts the next word only after that acknowledge matches the request.

---
 rtl/cdc_handshake_src.sv | 77 +++++++
 1 files changed

// File: rtl/cdc_handshake_src.sv
// cdc_handshake_src: launch side of a toggle-request / toggle-ack multi-bit CDC handshake.
// A word is held stable on bus_data from acceptance until the synchronized ack matches req_toggle.
module cdc_handshake_src #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  req_toggle,
    input  logic                  ack_async,
    output logic                  xfer_done,
    output logic                  proto_err
);
    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("cdc_handshake_src: NUM_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   bus_q;
    logic                    req_q;
    logic                    done_q;
    logic                    err_q;
    logic                    ack_sync;
    logic [NUM_STAGES-1:0]   ack_s_d;

    // The only flops that sample the foreign domain; keep them together, unretimed.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
    logic [NUM_STAGES-1:0]   ack_s_q;

    assign ack_s_d    = {ack_s_q[NUM_STAGES-2:0], ack_async};
    assign ack_sync   = ack_s_q[NUM_STAGES-1];
    assign src_ready  = (state_q == IDLE);
    assign bus_data   = bus_q;
    assign req_toggle = req_q;
    assign xfer_done  = done_q;
    assign proto_err  = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_s_q <= '0;
        end else begin
            ack_s_q <= ack_s_d;
        end
    end

    // bus_q and req_q update on the same edge so the destination never sees a new request with old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bus_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE && ack_sync != req_q) err_q <= 1'b1;
            if (state_q == IDLE) begin
                if (src_valid) begin
                    bus_q   <= src_data;
                    req_q   <= ~req_q;
                    state_q <= WAIT_ACK;
                end
            end else if (ack_sync == req_q) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
            end
        end
    end
endmodule
